// File: rtl/pspin_hostmem_dma_rd_mo.sv
// Multi-outstanding AXI read slave: DMA read descriptors into fixed RAM slots, R returned in AR order; PSPIN_HOSTMEM_RD_STATS_EN adds retire counters.
// Latency: AR handshake -> descriptor valid next cycle; status -> client read >= 2 cycles, then one RAM round trip per beat.
// Backpressure: arready drops when all slots are busy or a descriptor is pending; rvalid/descriptor held until accepted.
module pspin_hostmem_dma_rd_mo #(
    parameter int OUTSTANDING         = 4,
    parameter int MAX_BURST_BEATS     = 256,
    parameter int ADDR_WIDTH          = 64,
    parameter int DATA_WIDTH          = 512,
    parameter int ID_WIDTH            = 8,
    parameter int DMA_LEN_WIDTH       = 16,
    parameter int DMA_TAG_WIDTH       = 16,
    parameter int RAM_SEL_WIDTH       = 4,
    parameter int RAM_ADDR_WIDTH      = 20,
    parameter int RAM_SEG_COUNT       = 2,
    parameter int RAM_SEG_DATA_WIDTH  = 256,
    parameter int RAM_SEG_ADDR_WIDTH  = RAM_ADDR_WIDTH - $clog2(RAM_SEG_COUNT*RAM_SEG_DATA_WIDTH/8)
) (
    input  logic                                        clk,
    input  logic                                        rstn,
    output logic [ADDR_WIDTH-1:0]                       m_axis_read_desc_dma_addr,
    output logic [RAM_SEL_WIDTH-1:0]                    m_axis_read_desc_ram_sel,
    output logic [RAM_ADDR_WIDTH-1:0]                   m_axis_read_desc_ram_addr,
    output logic [DMA_LEN_WIDTH-1:0]                    m_axis_read_desc_len,
    output logic [DMA_TAG_WIDTH-1:0]                    m_axis_read_desc_tag,
    output logic                                        m_axis_read_desc_valid,
    input  logic                                        m_axis_read_desc_ready,
    input  logic [DMA_TAG_WIDTH-1:0]                    s_axis_read_desc_status_tag,
    input  logic [3:0]                                  s_axis_read_desc_status_error,
    input  logic                                        s_axis_read_desc_status_valid,
    output logic [RAM_SEG_COUNT*RAM_SEL_WIDTH-1:0]      ram_rd_cmd_sel,
    output logic [RAM_SEG_COUNT*RAM_SEG_ADDR_WIDTH-1:0] ram_rd_cmd_addr,
    output logic [RAM_SEG_COUNT-1:0]                    ram_rd_cmd_valid,
    input  logic [RAM_SEG_COUNT-1:0]                    ram_rd_cmd_ready,
    input  logic [RAM_SEG_COUNT*RAM_SEG_DATA_WIDTH-1:0] ram_rd_resp_data,
    input  logic [RAM_SEG_COUNT-1:0]                    ram_rd_resp_valid,
    output logic [RAM_SEG_COUNT-1:0]                    ram_rd_resp_ready,
    input  logic [ID_WIDTH-1:0]                         s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]                       s_axi_araddr,
    input  logic [7:0]                                  s_axi_arlen,
    input  logic [2:0]                                  s_axi_arsize,
    input  logic [1:0]                                  s_axi_arburst,
    input  logic                                        s_axi_arlock,
    input  logic [3:0]                                  s_axi_arcache,
    input  logic [2:0]                                  s_axi_arprot,
    input  logic [3:0]                                  s_axi_arqos,
    input  logic [3:0]                                  s_axi_arregion,
    input  logic                                        s_axi_aruser,
    input  logic                                        s_axi_arvalid,
    output logic                                        s_axi_arready,
    output logic [ID_WIDTH-1:0]                         s_axi_rid,
    output logic [DATA_WIDTH-1:0]                       s_axi_rdata,
    output logic [1:0]                                  s_axi_rresp,
    output logic                                        s_axi_rlast,
    output logic                                        s_axi_ruser,
    output logic                                        s_axi_rvalid,
    input  logic                                        s_axi_rready
`ifdef PSPIN_HOSTMEM_RD_STATS_EN
    ,
    output logic [31:0]                                 stat_bursts,
    output logic [31:0]                                 stat_beats,
    output logic [31:0]                                 stat_errors
`endif
);
    localparam int NB         = DATA_WIDTH / 8;
    localparam int SLOT_W     = $clog2(OUTSTANDING);
    localparam int CNT_W      = $clog2(OUTSTANDING + 1);
    localparam int SIZE_LOG   = $clog2(NB);
    localparam int SLOT_BYTES = MAX_BURST_BEATS * NB;
    localparam int ROW_SHIFT  = $clog2(RAM_SEG_COUNT * RAM_SEG_DATA_WIDTH / 8);
    localparam int SDW        = RAM_SEG_DATA_WIDTH;
    localparam int SAW        = RAM_SEG_ADDR_WIDTH;

    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DATA, R_ERR} rstate_t;

    logic [OUTSTANDING-1:0] busy_q, done_q, err_q;
    logic [ID_WIDTH-1:0]    id_q  [OUTSTANDING];
    logic [7:0]             len_q [OUTSTANDING];
    logic [SLOT_W-1:0]      alloc_ptr_q, ret_ptr_q, st_slot;
    logic [CNT_W-1:0]       count_q;
    logic                   rst_done_q, ar_hs, ar_legal, free;

    rstate_t                state_q, state_d;
    logic [SAW-1:0]         cl_row_q;
    logic [7:0]             cl_last_q, beat_q;
    logic [ID_WIDTH-1:0]    cl_id_q;
    logic [RAM_SEG_COUNT-1:0] cmd_sent_q, resp_got_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   r_hs;

    logic unused_ok;
    assign unused_ok = ^{s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                         s_axi_arregion, s_axi_aruser, s_axis_read_desc_status_tag};

    assign st_slot  = s_axis_read_desc_status_tag[SLOT_W-1:0];
    assign ar_hs    = s_axi_arvalid && s_axi_arready;
    assign ar_legal = (s_axi_arsize == 3'(SIZE_LOG)) && (s_axi_arburst == 2'b01) &&
                      (s_axi_araddr[SIZE_LOG-1:0] == '0) &&
                      (int'(s_axi_arlen) < MAX_BURST_BEATS);
    // rst_done_q keeps arready low while reset is asserted.
    assign s_axi_arready = rst_done_q && (int'(count_q) < OUTSTANDING) && !m_axis_read_desc_valid;
    assign m_axis_read_desc_ram_sel = '0;
    assign ram_rd_cmd_sel = '0;
    assign ram_rd_cmd_addr = {RAM_SEG_COUNT{cl_row_q}};
    assign s_axi_ruser = 1'b0;
    assign r_hs = s_axi_rvalid && s_axi_rready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_done_q <= 1'b0;
            busy_q <= '0; done_q <= '0; err_q <= '0;
            for (int i = 0; i < OUTSTANDING; i++) begin
                id_q[i]  <= '0;
                len_q[i] <= '0;
            end
            alloc_ptr_q <= '0; ret_ptr_q <= '0; count_q <= '0;
            m_axis_read_desc_valid <= 1'b0;
            m_axis_read_desc_dma_addr <= '0;
            m_axis_read_desc_ram_addr <= '0;
            m_axis_read_desc_len <= '0;
            m_axis_read_desc_tag <= '0;
        end else begin
            rst_done_q <= 1'b1;
            if (s_axis_read_desc_status_valid && busy_q[st_slot]) begin
                done_q[st_slot] <= 1'b1;
                err_q[st_slot]  <= (s_axis_read_desc_status_error != 4'd0);
            end
            if (ar_hs) begin
                busy_q[alloc_ptr_q] <= 1'b1;
                done_q[alloc_ptr_q] <= !ar_legal;
                err_q[alloc_ptr_q]  <= !ar_legal;
                id_q[alloc_ptr_q]   <= s_axi_arid;
                len_q[alloc_ptr_q]  <= s_axi_arlen;
                alloc_ptr_q         <= alloc_ptr_q + 1'b1;
            end
            if (free) begin
                busy_q[ret_ptr_q] <= 1'b0;
                done_q[ret_ptr_q] <= 1'b0;
                err_q[ret_ptr_q]  <= 1'b0;
                ret_ptr_q         <= ret_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(ar_hs) - CNT_W'(free);
            if (ar_hs && ar_legal) begin
                m_axis_read_desc_valid    <= 1'b1;
                m_axis_read_desc_dma_addr <= s_axi_araddr;
                m_axis_read_desc_len      <= DMA_LEN_WIDTH'((int'(s_axi_arlen) + 1) * NB);
                m_axis_read_desc_ram_addr <= RAM_ADDR_WIDTH'(int'(alloc_ptr_q) * SLOT_BYTES);
                m_axis_read_desc_tag      <= DMA_TAG_WIDTH'(alloc_ptr_q);
            end else if (m_axis_read_desc_ready) begin
                m_axis_read_desc_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        free = 1'b0;
        s_axi_rvalid = 1'b0;
        s_axi_rdata = '0;
        s_axi_rresp = 2'b00;
        s_axi_rid = '0;
        s_axi_rlast = 1'b0;
        ram_rd_cmd_valid = '0;
        ram_rd_resp_ready = '0;
        case (state_q)
            R_IDLE: begin
                if (busy_q[ret_ptr_q] && done_q[ret_ptr_q])
                    state_d = err_q[ret_ptr_q] ? R_ERR : R_ISSUE;
            end
            R_ISSUE: state_d = R_DATA;
            R_DATA: begin
                // One beat at a time: a row read on every segment, then present the beat.
                ram_rd_cmd_valid  = ~cmd_sent_q;
                ram_rd_resp_ready = ~resp_got_q;
                s_axi_rvalid = &resp_got_q;
                s_axi_rdata  = rdata_q;
                s_axi_rid    = cl_id_q;
                s_axi_rlast  = (beat_q == cl_last_q);
                if (r_hs && s_axi_rlast) begin
                    free = 1'b1;
                    state_d = R_IDLE;
                end
            end
            R_ERR: begin
                s_axi_rvalid = 1'b1;
                s_axi_rresp  = 2'b10;
                s_axi_rid    = id_q[ret_ptr_q];
                s_axi_rlast  = (beat_q == len_q[ret_ptr_q]);
                if (r_hs && s_axi_rlast) begin
                    free = 1'b1;
                    state_d = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= R_IDLE;
            cl_row_q <= '0; cl_last_q <= '0; cl_id_q <= '0; beat_q <= '0;
            cmd_sent_q <= '0; resp_got_q <= '0; rdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                R_IDLE: begin
                    beat_q <= '0;
                    cmd_sent_q <= '0;
                    resp_got_q <= '0;
                end
                R_ISSUE: begin
                    cl_row_q  <= SAW'((int'(ret_ptr_q) * SLOT_BYTES) >> ROW_SHIFT);
                    cl_last_q <= len_q[ret_ptr_q];
                    cl_id_q   <= id_q[ret_ptr_q];
                end
                R_DATA: begin
                    if (r_hs) begin
                        cmd_sent_q <= '0;
                        resp_got_q <= '0;
                        beat_q     <= beat_q + 8'd1;
                        cl_row_q   <= cl_row_q + 1'b1;
                    end else begin
                        cmd_sent_q <= cmd_sent_q | (ram_rd_cmd_valid & ram_rd_cmd_ready);
                        resp_got_q <= resp_got_q | (ram_rd_resp_valid & ram_rd_resp_ready);
                        for (int s = 0; s < RAM_SEG_COUNT; s++)
                            if (ram_rd_resp_valid[s] && ram_rd_resp_ready[s])
                                rdata_q[s*SDW +: SDW] <= ram_rd_resp_data[s*SDW +: SDW];
                    end
                end
                R_ERR: if (r_hs) beat_q <= beat_q + 8'd1;
                default: ;
            endcase
        end
    end

`ifdef PSPIN_HOSTMEM_RD_STATS_EN
    logic [31:0] stat_bursts_q, stat_beats_q, stat_errors_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_bursts_q <= '0; stat_beats_q <= '0; stat_errors_q <= '0;
        end else if (free) begin
            stat_bursts_q <= stat_bursts_q + 32'd1;
            stat_beats_q  <= stat_beats_q + 32'(len_q[ret_ptr_q]) + 32'd1;
            if (state_q == R_ERR) stat_errors_q <= stat_errors_q + 32'd1;
        end
    end
    assign stat_bursts = stat_bursts_q;
    assign stat_beats  = stat_beats_q;
    assign stat_errors = stat_errors_q;
`endif
endmodule

// File: tb/tb_pspin_hostmem_dma_rd_mo.sv
// Directed bench for pspin_hostmem_dma_rd_mo: RAM and DMA-engine models, R scoreboard by slot/beat.
// Latency: n/a. Backpressure: descriptor ready and rready driven by the stimulus.
module tb_pspin_hostmem_dma_rd_mo;
    localparam int SEG = 2, SDW = 256, SAW = 14;

    logic clk, rstn;
    logic [63:0] d_addr; logic [3:0] d_sel; logic [19:0] d_raddr; logic [15:0] d_len, d_tag;
    logic d_vld, d_rdy;
    logic [15:0] st_tag; logic [3:0] st_err; logic st_vld;
    logic [SEG*4-1:0] cmd_sel; logic [SEG*SAW-1:0] cmd_addr; logic [SEG-1:0] cmd_vld, cmd_rdy;
    logic [SEG*SDW-1:0] resp_dat; logic [SEG-1:0] resp_vld, resp_rdy;
    logic [7:0] arid, arlen; logic [63:0] araddr; logic [2:0] arsize; logic [1:0] arburst;
    logic arvalid, arready;
    logic [7:0] rid; logic [511:0] rdata; logic [1:0] rresp; logic rlast, ruser, rvalid, rready;
`ifdef PSPIN_HOSTMEM_RD_STATS_EN
    logic [31:0] stat_bursts, stat_beats, stat_errors;
`endif

    pspin_hostmem_dma_rd_mo dut (
        .clk(clk), .rstn(rstn),
        .m_axis_read_desc_dma_addr(d_addr), .m_axis_read_desc_ram_sel(d_sel),
        .m_axis_read_desc_ram_addr(d_raddr), .m_axis_read_desc_len(d_len),
        .m_axis_read_desc_tag(d_tag), .m_axis_read_desc_valid(d_vld),
        .m_axis_read_desc_ready(d_rdy),
        .s_axis_read_desc_status_tag(st_tag), .s_axis_read_desc_status_error(st_err),
        .s_axis_read_desc_status_valid(st_vld),
        .ram_rd_cmd_sel(cmd_sel), .ram_rd_cmd_addr(cmd_addr), .ram_rd_cmd_valid(cmd_vld),
        .ram_rd_cmd_ready(cmd_rdy), .ram_rd_resp_data(resp_dat), .ram_rd_resp_valid(resp_vld),
        .ram_rd_resp_ready(resp_rdy),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
        .s_axi_arqos(4'd0), .s_axi_arregion(4'd0), .s_axi_aruser(1'b0),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_ruser(ruser), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
`ifdef PSPIN_HOSTMEM_RD_STATS_EN
        , .stat_bursts(stat_bursts), .stat_beats(stat_beats), .stat_errors(stat_errors)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs = 0, checks = 0;
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // RAM model: each segment returns {8{row ^ seg_mark}} one cycle after the command.
    logic [SEG-1:0] pend;
    logic [SAW-1:0] paddr [SEG];
    assign cmd_rdy = '1;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) pend <= '0;
        else for (int s = 0; s < SEG; s++) begin
            if (resp_vld[s] && resp_rdy[s]) pend[s] <= 1'b0;
            if (cmd_vld[s]) begin
                pend[s] <= 1'b1;
                paddr[s] <= cmd_addr[s*SAW +: SAW];
            end
        end
    end
    always_comb begin
        resp_vld = pend;
        for (int s = 0; s < SEG; s++)
            resp_dat[s*SDW +: SDW] = {8{32'(paddr[s]) ^ (s == 1 ? 32'h1000_0000 : 32'h0)}};
    end

    logic [63:0] q_daddr[$], q_dlen[$], q_draddr[$], q_dtag[$];
    logic [63:0] q_id[$], q_resp[$], q_last[$], q_w[$], q_nz[$];
    logic hold; logic [63:0] h_addr, h_len, h_raddr, h_tag;
    bit rnd_en = 0;
    int rp = 0, next_slot = 0;

    always @(negedge clk) begin
        if (!rstn) hold = 1'b0;
        else begin
            if (hold) begin
                check("desc_stable_addr", d_addr, h_addr);
                check("desc_stable_len", 64'(d_len), h_len);
                check("desc_stable_raddr", 64'(d_raddr), h_raddr);
                check("desc_stable_tag", 64'(d_tag), h_tag);
            end
            hold = d_vld && !d_rdy;
            h_addr = d_addr; h_len = 64'(d_len); h_raddr = 64'(d_raddr); h_tag = 64'(d_tag);
            if (d_vld && d_rdy) begin
                q_daddr.push_back(d_addr); q_dlen.push_back(64'(d_len));
                q_draddr.push_back(64'(d_raddr)); q_dtag.push_back(64'(d_tag));
            end
            if (rvalid && rready) begin
                q_id.push_back(64'(rid)); q_resp.push_back(64'(rresp));
                q_last.push_back(64'(rlast)); q_nz.push_back(64'(|rdata));
                q_w.push_back({rdata[287:256], rdata[31:0]});
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_en) rready = 1'($urandom_range(0, 1));
    end

    task automatic send_ar(input logic [7:0] id, input logic [63:0] a, input logic [7:0] len,
                           input logic [2:0] size, output bit ok);
        ok = 0;
        arid = id; araddr = a; arlen = len; arsize = size; arburst = 2'b01; arvalid = 1'b1;
        for (int c = 0; c < 500 && !ok; c++) begin
            if (arready) ok = 1;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        if (!ok) check("ar_timeout", 0, 1);
        else next_slot = (next_slot + 1) % 4;
    endtask

    task automatic ar(input logic [7:0] id, input logic [63:0] a, input logic [7:0] len);
        bit ok;
        send_ar(id, a, len, 3'd6, ok);
    endtask

    task automatic send_status(input int tag, input logic [3:0] e);
        st_tag = 16'(tag); st_err = e; st_vld = 1'b1;
        @(posedge clk); #1;
        st_vld = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        for (int c = 0; c < 3000 && q_id.size() < n; c++) @(posedge clk);
        #2;
        if (q_id.size() < n) check("beats_timeout", 64'(q_id.size()), 64'(n));
    endtask

    task automatic wait_desc(input int n);
        for (int c = 0; c < 200 && q_daddr.size() < n; c++) @(posedge clk);
        #2;
        if (q_daddr.size() < n) check("desc_timeout", 64'(q_daddr.size()), 64'(n));
    endtask

    task automatic check_desc(input int i, input logic [63:0] a, input int beats, input int slot);
        if (i < q_daddr.size()) begin
            check("desc_addr", q_daddr[i], a);
            check("desc_len", q_dlen[i], 64'(beats * 64));
            check("desc_ram_addr", q_draddr[i], 64'(slot * 256 * 64));
            check("desc_tag", q_dtag[i], 64'(slot));
        end
    endtask

    task automatic check_ok(input int id, input int slot, input int n);
        for (int k = 0; k < n && rp < q_id.size(); k++) begin
            logic [31:0] w;
            w = 32'(slot * 256 + k);
            check("ok_id", q_id[rp], 64'(id));
            check("ok_resp", q_resp[rp], 64'd0);
            check("ok_last", q_last[rp], 64'(k == n - 1));
            check("ok_data", q_w[rp], {w ^ 32'h1000_0000, w});
            rp++;
        end
    endtask

    task automatic check_err(input int id, input int n);
        for (int k = 0; k < n && rp < q_id.size(); k++) begin
            check("err_id", q_id[rp], 64'(id));
            check("err_resp", q_resp[rp], 64'd2);
            check("err_last", q_last[rp], 64'(k == n - 1));
            check("err_data_zero", q_nz[rp], 64'd0);
            rp++;
        end
    endtask

    initial begin
        int s0, nd; bit ok;
        rstn = 0; d_rdy = 1; st_vld = 0; st_tag = 0; st_err = 0;
        arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_arready", 64'(arready), 0);
        check("rst_rvalid", 64'(rvalid), 0);
        check("rst_desc_valid", 64'(d_vld), 0);
        check("rst_cmd_valid", 64'(cmd_vld), 0);
        rstn = 1;
        @(posedge clk); #1;
        check("arready_after_rst", 64'(arready), 1);

        // 1: single burst
        ar(8'd3, 64'h1000, 8'd3);
        check("desc_latency", 64'(d_vld), 1);
        wait_desc(1);
        check_desc(0, 64'h1000, 4, 0);
        send_status(0, 4'd0);
        wait_beats(4);
        check_ok(3, 0, 4);

        // 2: four in flight, out-of-order completion, in-order R
        s0 = next_slot;
        for (int i = 1; i <= 4; i++) ar(8'(i), 64'(32'h10000 * i), 8'd1);
        check("full_arready", 64'(arready), 0);
        send_status(3, 4'd0);
        check("full_arready_hold", 64'(arready), 0);
        send_status(1, 4'd0); send_status(0, 4'd0); send_status(2, 4'd0);
        wait_beats(rp + 8);
        for (int i = 1; i <= 4; i++) check_ok(i, (s0 + i - 1) % 4, 2);
        s0 = next_slot;
        send_ar(8'd5, 64'h5000, 8'd0, 3'd6, ok);
        check("fifth_ar_accepted", 64'(ok), 1);
        send_status(s0, 4'd0);
        wait_beats(rp + 1);
        check_ok(5, s0, 1);

        // 3: narrow burst -> SLVERR without descriptor
        nd = q_daddr.size();
        send_ar(8'd7, 64'h6000, 8'd1, 3'd3, ok);
        wait_beats(rp + 2);
        check("illegal_no_desc", 64'(q_daddr.size()), 64'(nd));
        check_err(7, 2);

        // 4: DMA error on second of two bursts
        s0 = next_slot;
        ar(8'd8, 64'h7000, 8'd1);
        ar(8'd9, 64'h8000, 8'd2);
        wait_desc(nd + 2);
        send_status((s0 + 1) % 4, 4'h1);
        send_status(s0, 4'h0);
        wait_beats(rp + 5);
        check_ok(8, s0, 2);
        check_err(9, 3);

        // 5: descriptor and R backpressure
        s0 = next_slot; nd = q_daddr.size();
        d_rdy = 0;
        ar(8'd10, 64'h2040, 8'd3);
        repeat (10) @(posedge clk);
        #1;
        check("bp_desc_valid", 64'(d_vld), 1);
        check("bp_arready", 64'(arready), 0);
        rnd_en = 1;
        d_rdy = 1;
        wait_desc(nd + 1);
        check_desc(nd, 64'h2040, 4, s0);
        send_status(s0, 4'd0);
        wait_beats(rp + 4);
        check_ok(10, s0, 4);
        rnd_en = 0; rready = 1;

        // 6: reset in the middle of a data burst
        s0 = next_slot;
        ar(8'd11, 64'h4000, 8'd7);
        send_status(s0, 4'd0);
        wait_beats(rp + 2);
        @(posedge clk); #1;
        rstn = 0;
        #1;
        check("mid_rst_rvalid", 64'(rvalid), 0);
        check("mid_rst_arready", 64'(arready), 0);
        check("mid_rst_desc_valid", 64'(d_vld), 0);
        check("mid_rst_cmd_valid", 64'(cmd_vld), 0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1;
        q_id.delete(); q_resp.delete(); q_last.delete(); q_w.delete(); q_nz.delete();
        q_daddr.delete(); q_dlen.delete(); q_draddr.delete(); q_dtag.delete();
        rp = 0; next_slot = 0;
        @(posedge clk); #1;
        ar(8'd12, 64'h3000, 8'd0);
        wait_desc(1);
        check_desc(0, 64'h3000, 1, 0);
        send_status(0, 4'd0);
        wait_beats(1);
        check_ok(12, 0, 1);
        repeat (5) @(posedge clk);
        check("post_rst_no_extra_beats", 64'(q_id.size()), 64'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
